// File: rtl/simd_exec_wb.sv
// simd_exec_wb: two-stage SIMD execute/writeback stage behind a 32x16 register file.
// S1 captures the accepted instruction with forwarded operands, S2 holds the
// lane-wise ALU result that drives the register file write port.
// Optional build macro SIMD_SAT_EN: ADD saturates per lane to all-ones, SUB to 0.
module simd_exec_wb #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic              rs1_use,
    input  logic              rs2_use,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output logic              rd_wr_en,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    localparam int unsigned NIB_W = 4;
    localparam int unsigned NIBS  = DATA_W / NIB_W;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_MINU = 3'b101;
    localparam logic [2:0] OP_MAXU = 3'b110;

    localparam logic [1:0] MODE_2X8 = 2'b01;
    localparam logic [1:0] MODE_4X4 = 2'b10;

    // Stage 1 registers
    logic              s1_valid;
    logic [2:0]        s1_op;
    logic [1:0]        s1_mode;
    logic [ADDR_W-1:0] s1_rd;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;

    // Issue-side combinational signals
    logic              stall;
    logic              accept;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // ALU internals
    logic [NIBS-1:0]   lane_start;
    logic [NIBS-1:0]   lane_ge;
    logic [NIBS-1:0]   sub_cy;
    logic [DATA_W-1:0] add_sum;
    logic [DATA_W-1:0] sub_dif;
    logic [DATA_W-1:0] result;
    logic              cy_a;
    logic              cy_s;
    logic              cin_a;
    logic              cin_s;
    logic [NIB_W-1:0]  b_inv;
`ifdef SIMD_SAT_EN
    logic [NIBS-1:0]   add_cy;
    logic [NIBS-1:0]   lane_ovf;
`endif

    // RAW stall against the S1 destination, and forwarding from the write port
    always_comb begin
        stall    = s1_valid && (s1_rd != '0) &&
                   ((rs1_use && (rs1 == s1_rd)) || (rs2_use && (rs2 == s1_rd)));
        in_ready = !stall;
        accept   = in_valid && !stall;
        op_a     = rs1_data;
        op_b     = rs2_data;
        if (rd_wr_en && (rs1 != '0) && (rs1 == rd)) begin
            op_a = wr_data;
        end
        if (rd_wr_en && (rs2 != '0) && (rs2 == rd)) begin
            op_b = wr_data;
        end
    end

    // Nibble-sliced add/sub chains; carries are cut at each lane start
    always_comb begin
        lane_start = 4'b0001;
        case (s1_mode)
            MODE_2X8: lane_start = 4'b0101;
            MODE_4X4: lane_start = 4'b1111;
            default:  lane_start = 4'b0001;
        endcase
        add_sum = '0;
        sub_dif = '0;
        sub_cy  = '0;
        cy_a    = 1'b0;
        cy_s    = 1'b0;
        cin_a   = 1'b0;
        cin_s   = 1'b0;
        b_inv   = '0;
`ifdef SIMD_SAT_EN
        add_cy  = '0;
`endif
        for (int i = 0; i < NIBS; i++) begin
            cin_a = lane_start[i] ? 1'b0 : cy_a;
            cin_s = lane_start[i] ? 1'b1 : cy_s;
            b_inv = ~s1_b[NIB_W*i +: NIB_W];
            {cy_a, add_sum[NIB_W*i +: NIB_W]} = 5'(s1_a[NIB_W*i +: NIB_W]) +
                                                5'(s1_b[NIB_W*i +: NIB_W]) + 5'(cin_a);
            {cy_s, sub_dif[NIB_W*i +: NIB_W]} = 5'(s1_a[NIB_W*i +: NIB_W]) +
                                                5'(b_inv) + 5'(cin_s);
            sub_cy[i] = cy_s;
`ifdef SIMD_SAT_EN
            add_cy[i] = cy_a;
`endif
        end
    end

    // Broadcast each lane's top-nibble carry to every nibble of that lane
    always_comb begin
        case (s1_mode)
            MODE_4X4: lane_ge = sub_cy;
            MODE_2X8: lane_ge = {sub_cy[3], sub_cy[3], sub_cy[1], sub_cy[1]};
            default:  lane_ge = {4{sub_cy[3]}};
        endcase
`ifdef SIMD_SAT_EN
        case (s1_mode)
            MODE_4X4: lane_ovf = add_cy;
            MODE_2X8: lane_ovf = {add_cy[3], add_cy[3], add_cy[1], add_cy[1]};
            default:  lane_ovf = {4{add_cy[3]}};
        endcase
`endif
    end

    // Lane-wise result select
    always_comb begin
        result = '0;
        case (s1_op)
            OP_ADD: begin
`ifdef SIMD_SAT_EN
                for (int i = 0; i < NIBS; i++) begin
                    result[NIB_W*i +: NIB_W] = lane_ovf[i] ? '1 : add_sum[NIB_W*i +: NIB_W];
                end
`else
                result = add_sum;
`endif
            end
            OP_SUB: begin
`ifdef SIMD_SAT_EN
                for (int i = 0; i < NIBS; i++) begin
                    result[NIB_W*i +: NIB_W] = lane_ge[i] ? sub_dif[NIB_W*i +: NIB_W] : '0;
                end
`else
                result = sub_dif;
`endif
            end
            OP_AND: result = s1_a & s1_b;
            OP_OR:  result = s1_a | s1_b;
            OP_XOR: result = s1_a ^ s1_b;
            OP_MINU: begin
                for (int i = 0; i < NIBS; i++) begin
                    result[NIB_W*i +: NIB_W] = lane_ge[i] ? s1_b[NIB_W*i +: NIB_W]
                                                          : s1_a[NIB_W*i +: NIB_W];
                end
            end
            OP_MAXU: begin
                for (int i = 0; i < NIBS; i++) begin
                    result[NIB_W*i +: NIB_W] = lane_ge[i] ? s1_a[NIB_W*i +: NIB_W]
                                                          : s1_b[NIB_W*i +: NIB_W];
                end
            end
            default: result = s1_a;
        endcase
    end

    // Stage 1: capture accepted instruction; a stall or idle cycle leaves a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_mode  <= '0;
            s1_rd    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_op   <= op;
                s1_mode <= mode;
                s1_rd   <= rd_in;
                s1_a    <= op_a;
                s1_b    <= op_b;
            end
        end
    end

    // Stage 2: register file write port and occupancy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_wr_en <= 1'b0;
            rd       <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
        end else begin
            rd_wr_en <= s1_valid && (s1_rd != '0);
            if (s1_valid) begin
                rd      <= s1_rd;
                wr_data <= result;
            end
            busy <= accept || s1_valid;
        end
    end

endmodule

// File: tb/tb_simd_exec_wb.sv
// Bench for simd_exec_wb: program-order register file model plus lane-wise
// arithmetic reference; every cycle's write port, stall and busy are checked.
module tb_simd_exec_wb;

`ifdef SIMD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [1:0]  mode;
    logic [4:0]  rs1, rs2, rd_in;
    logic        rs1_use, rs2_use;
    logic [15:0] rs1_data, rs2_data;
    logic        rd_wr_en;
    logic [4:0]  rd;
    logic [15:0] wr_data;
    logic        busy;

    always #5 clk = ~clk;

    simd_exec_wb dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .mode(mode), .rs1(rs1), .rs2(rs2), .rs1_use(rs1_use),
        .rs2_use(rs2_use), .rd_in(rd_in), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rd_wr_en(rd_wr_en), .rd(rd), .wr_data(wr_data), .busy(busy)
    );

    // Environment register file, written only by the DUT write port
    logic [15:0] env_rf    [32];
    logic [15:0] init_vals [32];
    logic        rf_load;
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) env_rf[i] <= init_vals[i];
        end else if (rd_wr_en && rd != 5'd0) begin
            env_rf[rd] <= wr_data;
        end
    end
    assign rs1_data = env_rf[rs1];
    assign rs2_data = env_rf[rs2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    typedef struct { int due; logic [4:0] rd; logic [15:0] data; } wr_t;
    wr_t         q[$];
    logic [15:0] ref_rf [32];
    logic [15:0] snap   [32];
    bit          acc_at [0:8191];
    logic        s1_acc;
    logic [4:0]  s1_rd_m;
    logic        exp_ready_now;
    logic        chk_en;
    logic        post_rst;
    int          vecs = 0;
    int          errs = 0;
    int          give_up = 0;

    // Reference lane arithmetic from plain integer math
    function automatic logic [15:0] ref_alu(input logic [2:0] o, input logic [1:0] m,
                                            input logic [15:0] a, input logic [15:0] b);
        int w, mask, x, y, z;
        logic [15:0] r;
        w    = (m == 2'd1) ? 8 : (m == 2'd2) ? 4 : 16;
        mask = (1 << w) - 1;
        r    = '0;
        for (int k = 0; k < 16 / w; k++) begin
            x = (int'(a) >> (k * w)) & mask;
            y = (int'(b) >> (k * w)) & mask;
            case (o)
                3'd0: z = SAT ? ((x + y > mask) ? mask : x + y) : ((x + y) & mask);
                3'd1: z = SAT ? ((x >= y) ? x - y : 0) : ((x - y) & mask);
                3'd2: z = x & y;
                3'd3: z = x | y;
                3'd4: z = x ^ y;
                3'd5: z = (x < y) ? x : y;
                3'd6: z = (x > y) ? x : y;
                default: z = x;
            endcase
            r = r | 16'(z << (k * w));
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle output checks against the model
    task automatic cycle_checks();
        logic exp_we;
        logic exp_busy;
        if (chk_en) begin
            if (!rst) chk("in_ready", 32'(in_ready), 32'(exp_ready_now));
            exp_we = (q.size() > 0) && (q[0].due == cyc);
            chk("rd_wr_en", 32'(rd_wr_en), 32'(exp_we));
            if (exp_we) begin
                if (rd_wr_en) begin
                    chk("rd", 32'(rd), 32'(q[0].rd));
                    chk("wr_data", 32'(wr_data), 32'(q[0].data));
                end
                void'(q.pop_front());
            end
            exp_busy = acc_at[cyc] || (cyc > 0 && acc_at[cyc-1]);
            chk("busy", 32'(busy), 32'(exp_busy));
            if (post_rst) begin
                chk("rd_after_rst", 32'(rd), 32'd0);
                chk("wr_data_after_rst", 32'(wr_data), 32'd0);
            end
        end
        post_rst = 1'b0;
    endtask

    // One clock of stimulus; entered and left 1 time unit after a rising edge
    task automatic drive(input logic v, input logic [2:0] o, input logic [1:0] m,
                         input logic [4:0] a1, input logic [4:0] a2, input logic u1,
                         input logic u2, input logic [4:0] d, output logic acc);
        logic [15:0] av, bv, res;
        in_valid = v; op = o; mode = m; rs1 = a1; rs2 = a2;
        rs1_use = u1; rs2_use = u2; rd_in = d;
        exp_ready_now = !(s1_acc && s1_rd_m != 5'd0 &&
                          ((u1 && a1 == s1_rd_m) || (u2 && a2 == s1_rd_m)));
        #3;
        cycle_checks();
        acc = v && in_ready && !rst;
        if (acc) begin
            av  = (a1 == 5'd0) ? 16'd0 : ref_rf[a1];
            bv  = (a2 == 5'd0) ? 16'd0 : ref_rf[a2];
            res = ref_alu(o, m, av, bv);
            if (d != 5'd0) begin
                ref_rf[d] = res;
                q.push_back('{due: cyc + 2, rd: d, data: res});
            end
            acc_at[cyc + 1] = 1'b1;
        end
        s1_acc  = acc;
        s1_rd_m = d;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [1:0] m, input logic [4:0] a1,
                         input logic [4:0] a2, input logic u1, input logic u2,
                         input logic [4:0] d, output int tries);
        logic acc;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 8) begin
            drive(1'b1, o, m, a1, a2, u1, u2, d, acc);
            tries++;
        end
        if (!acc) give_up++;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, acc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        logic        acc;
        logic [2:0]  ro;
        for (int i = 0; i < 32; i++) init_vals[i] = (i == 0) ? 16'd0 : 16'($urandom);
        init_vals[10] = 16'h1234; init_vals[11] = 16'h0FFF;
        init_vals[12] = 16'h12FF; init_vals[13] = 16'h0101;
        init_vals[14] = 16'hFFFF; init_vals[15] = 16'h0001;
        init_vals[16] = 16'h0123; init_vals[17] = 16'h1111;
        init_vals[18] = 16'h80FF; init_vals[19] = 16'h7F01;
        for (int i = 0; i < 32; i++) ref_rf[i] = init_vals[i];
        rf_load = 1'b1; rst = 1'b1; chk_en = 1'b0; post_rst = 1'b0;
        s1_acc = 1'b0; s1_rd_m = 5'd0; exp_ready_now = 1'b1;
        in_valid = 1'b0; op = '0; mode = '0; rs1 = '0; rs2 = '0;
        rs1_use = 1'b0; rs2_use = 1'b0; rd_in = '0;

        // Hand-computed anchors for the reference model
        chk("pin_add_4x4",  32'(ref_alu(3'd0, 2'd2, 16'h1234, 16'h0FFF)), SAT ? 32'h1FFF : 32'h1123);
        chk("pin_add_2x8",  32'(ref_alu(3'd0, 2'd1, 16'h12FF, 16'h0101)), SAT ? 32'h13FF : 32'h1300);
        chk("pin_add_1x16", 32'(ref_alu(3'd0, 2'd0, 16'hFFFF, 16'h0001)), SAT ? 32'hFFFF : 32'h0000);
        chk("pin_sub_4x4",  32'(ref_alu(3'd1, 2'd2, 16'h0123, 16'h1111)), SAT ? 32'h0012 : 32'hF012);
        chk("pin_maxu_2x8", 32'(ref_alu(3'd6, 2'd1, 16'h80FF, 16'h7F01)), 32'h80FF);
        chk("pin_minu_2x8", 32'(ref_alu(3'd5, 2'd1, 16'h80FF, 16'h7F01)), 32'h7F01);

        @(posedge clk); #1;
        // in_valid high during reset must not be accepted
        for (int i = 0; i < 3; i++) drive(1'b1, 3'd0, 2'd0, 5'd10, 5'd11, 1'b1, 1'b1, 5'd3, acc);
        rf_load = 1'b0; rst = 1'b0; chk_en = 1'b1; post_rst = 1'b1;

        // Directed lane vectors
        issue(3'd0, 2'd2, 5'd10, 5'd11, 1'b1, 1'b1, 5'd3,  t);
        issue(3'd0, 2'd1, 5'd12, 5'd13, 1'b1, 1'b1, 5'd20, t);
        issue(3'd0, 2'd0, 5'd14, 5'd15, 1'b1, 1'b1, 5'd21, t);
        issue(3'd1, 2'd2, 5'd16, 5'd17, 1'b1, 1'b1, 5'd22, t);
        issue(3'd6, 2'd1, 5'd18, 5'd19, 1'b1, 1'b1, 5'd23, t);
        issue(3'd0, 2'd3, 5'd14, 5'd15, 1'b1, 1'b1, 5'd24, t);
        chk("r3_add_4x4", 32'(ref_rf[3]), SAT ? 32'h1FFF : 32'h1123);
        idle(3);

        // Dependent pair: one stall cycle, then forwarded operands
        issue(3'd0, 2'd0, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, t);
        chk("indep_tries", 32'(t), 32'd1);
        issue(3'd0, 2'd0, 5'd1, 5'd1, 1'b1, 1'b1, 5'd4, t);
        chk("dep_stall_tries", 32'(t), 32'd2);
        idle(3);

        // r0 destination writes nothing; reading r0 never stalls
        issue(3'd0, 2'd0, 5'd10, 5'd11, 1'b1, 1'b1, 5'd0, t);
        issue(3'd0, 2'd0, 5'd0, 5'd10, 1'b1, 1'b1, 5'd9, t);
        chk("r0_no_stall_tries", 32'(t), 32'd1);
        idle(3);

        // Reset with both stages valid: S2 writes this cycle, S1 is dropped
        issue(3'd0, 2'd0, 5'd10, 5'd11, 1'b1, 1'b1, 5'd5, t);
        for (int i = 0; i < 32; i++) snap[i] = ref_rf[i];
        issue(3'd4, 2'd1, 5'd12, 5'd13, 1'b1, 1'b1, 5'd6, t);
        rst = 1'b1;
        drive(1'b1, 3'd3, 2'd0, 5'd14, 5'd15, 1'b1, 1'b1, 5'd7, acc);
        rst = 1'b0;
        q.delete();
        acc_at[cyc] = 1'b0;
        acc_at[cyc - 1] = 1'b0;
        for (int i = 0; i < 32; i++) ref_rf[i] = snap[i];
        post_rst = 1'b1;
        idle(1);
        issue(3'd7, 2'd0, 5'd6, 5'd0, 1'b1, 1'b0, 5'd7, t);
        issue(3'd7, 2'd0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd8, t);
        idle(3);

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                ro = 3'($urandom_range(0, 7));
                issue(ro, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 1'b1,
                      (ro == 3'd7) ? 1'($urandom_range(0, 1)) : 1'b1,
                      5'($urandom_range(0, 7)), t);
            end else begin
                idle(1);
            end
        end
        idle(4);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("issue_timeouts", 32'(give_up), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
